// File: rtl/io_peer_if.sv
// Processor-side four-phase handshake bundle: request/data from the processor,
// acknowledge/return byte back from the peer.
interface io_peer_if;
    logic       proc_hs_out;
    logic [7:0] proc_bus_out;
    logic [7:0] proc_bus_in;
    logic       proc_hs_in;

    modport master (
        output proc_hs_out,
        output proc_bus_out,
        input  proc_bus_in,
        input  proc_hs_in
    );

    modport slave (
        input  proc_hs_out,
        input  proc_bus_out,
        output proc_bus_in,
        output proc_hs_in
    );
endinterface

// File: rtl/io_peer.sv
// IO peer: answers each processor four-phase handshake by capturing the
// processor byte and returning the head of an outbound FIFO, or a filler
// byte (8'hFF) when no data shows up within TIMEOUT cycles.
module io_peer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   g_clk,
    input  logic                   g_clr,
    io_peer_if.slave               proc,
    input  logic [7:0]             tx_data,
    input  logic                   tx_push,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   flag_clr,
    output logic                   underrun,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SETUP = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    logic [7:0]    r_busIn;
    logic          r_hsIn;
    logic [7:0]    r_rxData;
    logic          r_rxValid;
    logic          r_underrun;
    logic          r_overflow;
    logic [CW-1:0] r_waitCnt;
    logic          r_noPop;
    logic          r_armed;

    logic          w_notEmpty;
    logic          w_full;
    logic [7:0]    w_head;
    logic          w_push;
    logic          w_drop;
    logic          w_capture;
    logic          w_loadHead;
    logic          w_loadFill;
    logic          w_hsInSet;
    logic          w_hsInClr;
    logic          w_pop;
    logic          w_cntClr;
    logic          w_cntInc;

    assign w_notEmpty = (r_count != '0);
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_head     = r_mem[r_rdPtr];
    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign w_push     = tx_push && (!w_full || w_pop);
    assign w_drop     = tx_push && w_full && !w_pop;

    assign proc.proc_bus_in = r_busIn;
    assign proc.proc_hs_in  = r_hsIn;
    assign tx_full          = w_full;
    assign tx_count         = r_count;
    assign rx_data          = r_rxData;
    assign rx_valid         = r_rxValid;
    assign underrun         = r_underrun;
    assign overflow         = r_overflow;

    // Handshake state register.
    always_ff @(posedge g_clk) begin
        if (g_clr)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // Next-state decode and per-edge control strobes for the datapath.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_loadHead  = 1'b0;
        w_loadFill  = 1'b0;
        w_hsInSet   = 1'b0;
        w_hsInClr   = 1'b0;
        w_pop       = 1'b0;
        w_cntClr    = 1'b0;
        w_cntInc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (proc.proc_hs_out && r_armed) begin
                    w_capture = 1'b1;
                    if (w_notEmpty) begin
                        w_loadHead  = 1'b1;
                        w_nextState = SETUP;
                    end else begin
                        w_cntClr    = 1'b1;
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!proc.proc_hs_out) begin
                    w_nextState = IDLE;
                end else if (w_notEmpty) begin
                    w_loadHead  = 1'b1;
                    w_nextState = SETUP;
                end else if (r_waitCnt == CW'(TIMEOUT - 1)) begin
                    w_loadFill  = 1'b1;
                    w_nextState = SETUP;
                end else begin
                    w_cntInc = 1'b1;
                end
            end
            SETUP: begin
                if (!proc.proc_hs_out) begin
                    w_nextState = IDLE;
                end else begin
                    w_hsInSet   = 1'b1;
                    w_nextState = ACK;
                end
            end
            ACK: begin
                if (!proc.proc_hs_out) begin
                    w_hsInClr   = 1'b1;
                    w_pop       = !r_noPop && w_notEmpty;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake datapath: return byte, acknowledge, capture, wait counter and re-arm tracking.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_busIn   <= 8'h00;
            r_hsIn    <= 1'b0;
            r_rxData  <= 8'h00;
            r_rxValid <= 1'b0;
            r_waitCnt <= '0;
            r_noPop   <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_rxValid <= w_capture;
            if (w_capture)
                r_rxData <= proc.proc_bus_out;
            if (w_loadHead) begin
                r_busIn <= w_head;
                r_noPop <= 1'b0;
            end else if (w_loadFill) begin
                r_busIn <= 8'hFF;
                r_noPop <= 1'b1;
            end
            if (w_hsInSet)
                r_hsIn <= 1'b1;
            else if (w_hsInClr)
                r_hsIn <= 1'b0;
            if (w_cntClr)
                r_waitCnt <= '0;
            else if (w_cntInc)
                r_waitCnt <= r_waitCnt + 1'b1;
            if (!proc.proc_hs_out)
                r_armed <= 1'b1;
        end
    end

    // Outbound FIFO storage, wrapping pointers and occupancy.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= tx_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky status flags; a set event on the same edge beats flag_clr.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_underrun <= w_loadFill | (r_underrun & ~flag_clr);
            r_overflow <= w_drop     | (r_overflow & ~flag_clr);
        end
    end
endmodule

// File: tb/tb_io_peer.sv
// Bench for io_peer: directed sequence with random data bytes, checked against
// a queue-based model of the outbound FIFO and the sticky flags.
module tb_io_peer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       g_clk = 1'b0;
    logic       g_clr;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       tx_full;
    logic [2:0] tx_count;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       flag_clr;
    logic       underrun;
    logic       overflow;

    io_peer_if pif ();

    io_peer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .g_clk    (g_clk),
        .g_clr    (g_clr),
        .proc     (pif),
        .tx_data  (tx_data),
        .tx_push  (tx_push),
        .tx_full  (tx_full),
        .tx_count (tx_count),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .flag_clr (flag_clr),
        .underrun (underrun),
        .overflow (overflow)
    );

    always #5 g_clk = ~g_clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [7:0] q[$];
    bit         expUnderrun = 1'b0;
    bit         expOverflow = 1'b0;

    // Random data byte.
    function automatic logic [7:0] rb();
        return 8'($urandom);
    endfunction

    // Advance to the falling edge after the given number of rising edges.
    task automatic stepCycles(input int cycles);
        repeat (cycles) @(negedge g_clk);
    endtask

    // Compare one observed value against the model.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One idle-cycle of device-side activity (push and/or flag clear) plus its model update.
    task automatic applyStimulus(input bit push, input logic [7:0] data, input bit fclr);
        tx_push  = push;
        tx_data  = data;
        flag_clr = fclr;
        stepCycles(1);
        tx_push  = 1'b0;
        flag_clr = 1'b0;
        if (fclr) begin
            expUnderrun = 1'b0;
            expOverflow = 1'b0;
        end
        if (push) begin
            if (q.size() < DEPTH) q.push_back(data);
            else expOverflow = 1'b1;
        end
    endtask

    // Full processor exchange; optional late push while waiting and optional push on release.
    task automatic runExchange(input logic [7:0] sent, input int pushStep, input logic [7:0] pushByte,
                               input bit pushOnDrop, input logic [7:0] dropByte);
        int         n;
        int         extra;
        int         expN;
        bit         filler;
        logic [7:0] expByte;
        filler = (q.size() == 0) && (pushStep <= 0);
        if (q.size() != 0)     expN = 2;
        else if (pushStep > 0) expN = pushStep + 3;
        else                   expN = TIMEOUT + 2;
        pif.proc_bus_out = sent;
        pif.proc_hs_out  = 1'b1;
        stepCycles(1);
        checkOutput("rx_valid_strobe", 16'(rx_valid), 16'd1);
        checkOutput("rx_data", 16'(rx_data), 16'(sent));
        n     = 1;
        extra = 0;
        while (pif.proc_hs_in !== 1'b1 && n < TIMEOUT + 8) begin
            if (n == pushStep) begin
                tx_data = pushByte;
                tx_push = 1'b1;
            end
            stepCycles(1);
            n++;
            if (tx_push) begin
                tx_push = 1'b0;
                q.push_back(pushByte);
            end
            if (rx_valid !== 1'b0) extra++;
        end
        expByte = filler ? 8'hFF : q[0];
        if (filler) expUnderrun = 1'b1;
        checkOutput("hs_in_latency", 16'(n), 16'(expN));
        checkOutput("rx_valid_single", 16'(extra), 16'd0);
        checkOutput("bus_in", 16'(pif.proc_bus_in), 16'(expByte));
        checkOutput("underrun", 16'(underrun), 16'(expUnderrun));
        stepCycles(2);
        checkOutput("hs_in_hold", 16'(pif.proc_hs_in), 16'd1);
        checkOutput("bus_in_hold", 16'(pif.proc_bus_in), 16'(expByte));
        pif.proc_hs_out = 1'b0;
        if (pushOnDrop) begin
            tx_push = 1'b1;
            tx_data = dropByte;
        end
        stepCycles(1);
        tx_push = 1'b0;
        if (!filler) void'(q.pop_front());
        if (pushOnDrop) begin
            if (q.size() < DEPTH) q.push_back(dropByte);
            else expOverflow = 1'b1;
        end
        checkOutput("hs_in_release", 16'(pif.proc_hs_in), 16'd0);
        checkOutput("tx_count_after", 16'(tx_count), 16'(q.size()));
        checkOutput("overflow", 16'(overflow), 16'(expOverflow));
        checkOutput("bus_in_keep", 16'(pif.proc_bus_in), 16'(expByte));
        stepCycles(1);
    endtask

    // Safety net in case the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [7:0] sent;
        logic [7:0] lastBus;
        bit         seenHs;
        bit         seenRx;

        g_clr            = 1'b1;
        tx_push          = 1'b0;
        tx_data          = 8'h00;
        flag_clr         = 1'b0;
        pif.proc_hs_out  = 1'b0;
        pif.proc_bus_out = 8'h00;
        stepCycles(2);
        g_clr = 1'b0;
        stepCycles(1);

        checkOutput("rst_hs_in", 16'(pif.proc_hs_in), 16'd0);
        checkOutput("rst_bus_in", 16'(pif.proc_bus_in), 16'h00);
        checkOutput("rst_rx_data", 16'(rx_data), 16'h00);
        checkOutput("rst_rx_valid", 16'(rx_valid), 16'd0);
        checkOutput("rst_underrun", 16'(underrun), 16'd0);
        checkOutput("rst_overflow", 16'(overflow), 16'd0);
        checkOutput("rst_tx_count", 16'(tx_count), 16'd0);
        checkOutput("rst_tx_full", 16'(tx_full), 16'd0);

        // Two queued bytes, then exchanges that drain them and hit the filler path.
        applyStimulus(1'b1, rb(), 1'b0);
        applyStimulus(1'b1, rb(), 1'b0);
        checkOutput("tx_count_two", 16'(tx_count), 16'(q.size()));
        runExchange(rb(), 0, 8'h00, 1'b0, 8'h00);
        runExchange(rb(), 0, 8'h00, 1'b0, 8'h00);
        runExchange(rb(), 0, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("underrun_cleared", 16'(underrun), 16'(expUnderrun));

        // Data arriving mid-wait is returned instead of the filler.
        runExchange(rb(), 5, rb(), 1'b0, 8'h00);

        // Overflow: one more push than the FIFO holds.
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, rb(), 1'b0);
        checkOutput("full_flag", 16'(tx_full), 16'd1);
        checkOutput("overflow_set", 16'(overflow), 16'(expOverflow));
        checkOutput("full_count", 16'(tx_count), 16'(q.size()));
        applyStimulus(1'b1, rb(), 1'b1);
        checkOutput("overflow_set_wins", 16'(overflow), 16'(expOverflow));
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("overflow_cleared", 16'(overflow), 16'(expOverflow));

        // Push on the pop edge while full, then drain in order across pointer wrap.
        runExchange(rb(), 0, 8'h00, 1'b1, rb());
        checkOutput("full_after_swap", 16'(tx_full), 16'd1);
        for (int i = 0; i < DEPTH; i++) runExchange(rb(), 0, 8'h00, 1'b0, 8'h00);
        checkOutput("drained", 16'(tx_count), 16'd0);

        // Abort during WAIT.
        lastBus          = pif.proc_bus_in;
        sent             = rb();
        pif.proc_bus_out = sent;
        pif.proc_hs_out  = 1'b1;
        stepCycles(4);
        checkOutput("abort_rx_data", 16'(rx_data), 16'(sent));
        pif.proc_hs_out = 1'b0;
        seenHs = 1'b0;
        for (int i = 0; i < TIMEOUT + 4; i++) begin
            stepCycles(1);
            if (pif.proc_hs_in !== 1'b0) seenHs = 1'b1;
        end
        checkOutput("abort_no_hs_in", 16'(seenHs), 16'd0);
        checkOutput("abort_no_underrun", 16'(underrun), 16'(expUnderrun));
        checkOutput("abort_bus_in_keep", 16'(pif.proc_bus_in), 16'(lastBus));

        // Reset while in ACK, with a push on the reset edge and flags set.
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, rb(), 1'b0);
        pif.proc_bus_out = rb();
        pif.proc_hs_out  = 1'b1;
        stepCycles(2);
        checkOutput("pre_reset_ack", 16'(pif.proc_hs_in), 16'd1);
        g_clr   = 1'b1;
        tx_push = 1'b1;
        tx_data = rb();
        stepCycles(1);
        g_clr   = 1'b0;
        tx_push = 1'b0;
        q.delete();
        expUnderrun = 1'b0;
        expOverflow = 1'b0;
        checkOutput("ack_rst_hs_in", 16'(pif.proc_hs_in), 16'd0);
        checkOutput("ack_rst_tx_count", 16'(tx_count), 16'd0);
        checkOutput("ack_rst_tx_full", 16'(tx_full), 16'd0);
        checkOutput("ack_rst_overflow", 16'(overflow), 16'd0);
        checkOutput("ack_rst_underrun", 16'(underrun), 16'd0);
        checkOutput("ack_rst_bus_in", 16'(pif.proc_bus_in), 16'h00);
        checkOutput("ack_rst_rx_data", 16'(rx_data), 16'h00);

        // Request still held high after reset must not start an exchange.
        applyStimulus(1'b1, rb(), 1'b0);
        seenHs = 1'b0;
        seenRx = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stepCycles(1);
            if (pif.proc_hs_in !== 1'b0) seenHs = 1'b1;
            if (rx_valid !== 1'b0)       seenRx = 1'b1;
        end
        checkOutput("held_no_hs_in", 16'(seenHs), 16'd0);
        checkOutput("held_no_rx_valid", 16'(seenRx), 16'd0);
        checkOutput("held_count", 16'(tx_count), 16'(q.size()));
        pif.proc_hs_out = 1'b0;
        stepCycles(1);
        runExchange(rb(), 0, 8'h00, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/io_peer.md
IO_PEER -- requirements
Module: io_peer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: outbound FIFO entries, power of two.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles to wait for data before answering with a filler byte.
REQ-003 SHALL have port g_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port g_clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port proc_hs_out  input  1  processor request (processor hs_out).
REQ-006 SHALL have port proc_bus_out  input  8  processor data, valid while proc_hs_out=1.
REQ-007 SHALL have port proc_bus_in  output  8  byte returned to processor (processor bus_in).
REQ-008 SHALL have port proc_hs_in  output  1  acknowledge to processor (processor hs_in).
REQ-009 SHALL have port tx_data  input  8  device byte to queue toward processor.
REQ-010 SHALL have port tx_push  input  1  enqueue tx_data this cycle.
REQ-011 SHALL have port tx_full  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port tx_count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port rx_data  output  8  last byte captured from processor.
REQ-014 SHALL have port rx_valid  output  1  one-cycle strobe: rx_data updated.
REQ-015 SHALL have port flag_clr  input  1  clears sticky flags.
REQ-016 SHALL have port underrun  output  1  sticky: a filler byte was returned.
REQ-017 SHALL have port overflow  output  1  sticky: a push was dropped.

Function
REQ-018 SHALL implement four-phase exchange: each handshake captures one byte from processor and returns one byte.
REQ-019 SHALL use FSM states IDLE, WAIT, SETUP, ACK.
REQ-020 IDLE, proc_hs_out=1 at edge k: SHALL capture proc_bus_out into rx_data; rx_valid=1 for the cycle after k only.
REQ-021 Same edge: FIFO non-empty -> proc_bus_in<=head, state SETUP; empty -> state WAIT, wait counter<=0.
REQ-022 WAIT: FIFO non-empty -> proc_bus_in<=head, SETUP; else counter==TIMEOUT-1 -> proc_bus_in<=8'hFF, underrun<=1, SETUP with no-pop mark; else counter+1.
REQ-023 SETUP: proc_hs_in<=1, state ACK; proc_bus_in stable at least one cycle before proc_hs_in rises.
REQ-024 ACK: hold proc_hs_in=1 and proc_bus_in until proc_hs_out sampled 0; then proc_hs_in<=0, pop head (unless no-pop mark), state IDLE.
REQ-025 Latency with data queued: request seen at edge k -> proc_hs_in=1 after edge k+1.
REQ-026 Latency with empty FIFO and no push: proc_hs_in=1 after edge k+TIMEOUT+1.
REQ-027 proc_hs_out dropping in WAIT or SETUP SHALL abort: state IDLE, proc_hs_in stays 0, no pop, no underrun.
REQ-028 IDLE SHALL not start a new exchange until proc_hs_out sampled 1 again; a held-high request after ACK does not count.
REQ-029 proc_bus_in SHALL hold its last value between exchanges.
REQ-030 tx_push with FIFO not full SHALL enqueue; full with no same-cycle pop -> drop, overflow<=1.
REQ-031 tx_push and pop on same edge SHALL both occur, count unchanged, including when full.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH; ordering strictly FIFO.
REQ-033 flag_clr SHALL clear underrun and overflow; a same-cycle set event wins.

Reset
REQ-034 g_clr=1 at an edge, any state including mid-handshake: state IDLE, FIFO empty, proc_hs_in=0, proc_bus_in=8'h00, rx_data=8'h00, rx_valid=0, underrun=0, overflow=0, counter=0; tx_count=0, tx_full=0.
REQ-035 g_clr SHALL override tx_push and proc_hs_out on the same edge.

Verification
REQ-036 Push 8'hA1, 8'hB2; processor exchange sending 8'h3C -> rx_data=8'h3C with single rx_valid; proc_bus_in=8'hA1, hs_in after edge k+1; tx_count 2->1 after hs_out drops.
REQ-037 Empty FIFO, request held -> after edge k+17 proc_hs_in=1, proc_bus_in=8'hFF, underrun=1, tx_count stays 0.
REQ-038 Empty FIFO, request; push 8'h55 at cycle 5 -> proc_bus_in=8'h55, underrun=0, FIFO empty after exchange.
REQ-039 Push 5 bytes with DEPTH=4 -> 5th dropped, overflow=1, tx_full=1; push during an ACK pop when full -> accepted, count stays 4.
REQ-040 Assert g_clr while in ACK -> next cycle proc_hs_in=0, tx_count=0, flags 0; hs_out still high -> no new exchange until it drops and rises.
REQ-041 Drop proc_hs_out during WAIT -> IDLE, no filler, underrun=0, proc_hs_in never asserted.
